// File: rtl/eth_tx_frame_packer_if.sv
// Handshake bundle between the MMIO frame-data register, the packer and the MAC TX AXI-Stream port.
// The master modport is the packer; the slave modport is its environment.
`timescale 1ns/1ps
interface eth_tx_frame_packer_if #(
  parameter int unsigned axis_data_width_p = 64
);
  logic [axis_data_width_p-1:0]   frame_data_i;
  logic                           frame_data_v_i;
  logic                           frame_data_yumi_o;
  logic [1:0]                     tx_ext_state_o;
  logic                           error_o;
  logic                           error_clr_i;
  logic [axis_data_width_p-1:0]   tx_axis_tdata_o;
  logic [axis_data_width_p/8-1:0] tx_axis_tkeep_o;
  logic                           tx_axis_tvalid_o;
  logic                           tx_axis_tready_i;
  logic                           tx_axis_tlast_o;
  logic                           tx_axis_tuser_o;

  modport master (
    input  frame_data_i, frame_data_v_i, error_clr_i, tx_axis_tready_i,
    output frame_data_yumi_o, tx_ext_state_o, error_o,
           tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tuser_o
  );

  modport slave (
    output frame_data_i, frame_data_v_i, error_clr_i, tx_axis_tready_i,
    input  frame_data_yumi_o, tx_ext_state_o, error_o,
           tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tuser_o
  );
endinterface

// File: rtl/eth_tx_frame_packer.sv
// Store-and-forward TX framer: buffers a whole descriptor-sized frame written over MMIO,
// then streams it to the MAC as one AXIS packet with registered tdata/tkeep/tlast/tvalid.
`timescale 1ns/1ps
module eth_tx_frame_packer #(
  parameter int unsigned axis_data_width_p = 64,
  parameter int unsigned max_frame_bytes_p = 1536,
  parameter int unsigned len_width_p       = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  eth_tx_frame_packer_if.master io
);

  localparam int unsigned depth_lp  = max_frame_bytes_p / 8;
  localparam int unsigned ptr_w_lp  = $clog2(depth_lp);
  localparam int unsigned keep_w_lp = axis_data_width_p / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Byte enables of the final beat given the frame length modulo 8.
  function automatic logic [keep_w_lp-1:0] last_keep(input logic [2:0] rem);
    if (rem == 3'd0) begin
      return {keep_w_lp{1'b1}};
    end else begin
      return (8'h01 << rem) - 8'h01;
    end
  endfunction

  state_e                       state_q, state_d;
  logic [2:0]                   len_rem_q, len_rem_d;
  logic [ptr_w_lp-1:0]          last_idx_q, last_idx_d;
  logic [ptr_w_lp-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]          rd_ptr_q, rd_ptr_d;
  logic                         error_q, error_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tlast_q, tlast_d;
  logic [keep_w_lp-1:0]         tkeep_q, tkeep_d;
  logic [axis_data_width_p-1:0] tdata_q, tdata_d;
  logic [axis_data_width_p-1:0] buf_q [depth_lp];

  logic [len_width_p-1:0]       desc_len_s, desc_len_m1_s;
  logic                         desc_ok_s;
  logic                         yumi_s;
  logic                         buf_we_s;
  logic                         err_set_s;
  logic                         ld_s;
  logic [ptr_w_lp-1:0]          ld_idx_s;
  logic [axis_data_width_p-1:0] ld_word_s;

  assign desc_len_s    = io.frame_data_i[len_width_p-1:0];
  assign desc_len_m1_s = desc_len_s - {{(len_width_p-1){1'b0}}, 1'b1};
  assign desc_ok_s     = (desc_len_s != {len_width_p{1'b0}}) &&
                         (desc_len_s <= len_width_p'(max_frame_bytes_p));
  // Ready is held low while reset is asserted so no write is reported consumed.
  assign yumi_s = reset_n_i & io.frame_data_v_i &
                  ((state_q == ST_IDLE) || (state_q == ST_FILL));

  // Next-state, pointer and output-beat logic.
  always_comb begin
    state_d    = state_q;
    len_rem_d  = len_rem_q;
    last_idx_d = last_idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tkeep_d    = tkeep_q;
    tdata_d    = tdata_q;
    buf_we_s   = 1'b0;
    err_set_s  = 1'b0;
    ld_s       = 1'b0;
    ld_idx_s   = {ptr_w_lp{1'b0}};
    ld_word_s  = {axis_data_width_p{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (yumi_s && desc_ok_s) begin
          len_rem_d  = desc_len_s[2:0];
          last_idx_d = ptr_w_lp'(desc_len_m1_s >> 3);
          wr_ptr_d   = {ptr_w_lp{1'b0}};
          state_d    = ST_FILL;
        end else begin
          err_set_s = yumi_s;
        end
      end
      ST_FILL: begin
        if (yumi_s) begin
          buf_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
          if (wr_ptr_q == last_idx_q) begin
            // Beat 0 is preloaded; for a one-word frame it is the word being written now.
            state_d   = ST_SEND;
            rd_ptr_d  = {ptr_w_lp{1'b0}};
            ld_s      = 1'b1;
            ld_word_s = (last_idx_q == {ptr_w_lp{1'b0}}) ? io.frame_data_i : buf_q[0];
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_SEND: begin
        if (io.tx_axis_tready_i && tlast_q) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tkeep_d  = {keep_w_lp{1'b0}};
          tdata_d  = {axis_data_width_p{1'b0}};
        end else if (io.tx_axis_tready_i) begin
          rd_ptr_d  = rd_ptr_q + ptr_w_lp'(1);
          ld_s      = 1'b1;
          ld_idx_s  = rd_ptr_q + ptr_w_lp'(1);
          ld_word_s = buf_q[ld_idx_s];
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ld_s) begin
      tvalid_d = 1'b1;
      tdata_d  = ld_word_s;
      tlast_d  = (ld_idx_s == last_idx_q);
      tkeep_d  = tlast_d ? last_keep(len_rem_q) : {keep_w_lp{1'b1}};
    end else begin
      tvalid_d = tvalid_d;
    end

    // A new bad descriptor beats a simultaneous clear.
    error_d = err_set_s | (error_q & ~io.error_clr_i);
  end

  // Control state, pointers, sticky error and registered stream outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= ST_IDLE;
      len_rem_q  <= 3'd0;
      last_idx_q <= {ptr_w_lp{1'b0}};
      wr_ptr_q   <= {ptr_w_lp{1'b0}};
      rd_ptr_q   <= {ptr_w_lp{1'b0}};
      error_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= {keep_w_lp{1'b0}};
      tdata_q    <= {axis_data_width_p{1'b0}};
    end else begin
      state_q    <= state_d;
      len_rem_q  <= len_rem_d;
      last_idx_q <= last_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      error_q    <= error_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
      tdata_q    <= tdata_d;
    end
  end

  // Frame buffer storage; contents are only read after being written.
  always_ff @(posedge clk_i) begin
    if (buf_we_s) begin
      buf_q[wr_ptr_q] <= io.frame_data_i;
    end
  end

  assign io.frame_data_yumi_o = yumi_s;
  assign io.tx_ext_state_o    = state_q;
  assign io.error_o           = error_q;
  assign io.tx_axis_tdata_o   = tdata_q;
  assign io.tx_axis_tkeep_o   = tkeep_q;
  assign io.tx_axis_tvalid_o  = tvalid_q;
  assign io.tx_axis_tlast_o   = tlast_q;
  assign io.tx_axis_tuser_o   = 1'b0;

endmodule

// File: doc/eth_tx_frame_packer.md
# eth_tx_frame_packer

Store-and-forward transmit framer between the MMIO frame-data write register and the TX AXI-Stream input of the 1G RGMII MAC. Software writes a length descriptor, then the frame payload as 64-bit words. The block buffers the whole frame and only then streams it as an AXIS packet with correct `tkeep`/`tlast`, so the MAC TX FIFO never sees an underflow mid-frame. It also reports a 2-bit transmit state for software polling.

## Interface
Parameters:
- `axis_data_width_p`, 64, AXIS data width; only 64 is supported.
- `max_frame_bytes_p`, 1536, largest accepted frame length in bytes; must be a multiple of 8.
- `len_width_p`, 16, width of the descriptor length field.

Ports:
- `clk_i` in 1: BP clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `frame_data_i` in 64: MMIO write data (descriptor or payload word).
- `frame_data_v_i` in 1: write data valid.
- `frame_data_yumi_o` out 1: write consumed this cycle.
- `tx_ext_state_o` out 2: 0 = IDLE, 1 = FILL, 2 = SEND.
- `error_o` out 1: sticky descriptor error.
- `error_clr_i` in 1: clears `error_o`.
- `tx_axis_tdata_o` out 64: stream data; frame byte k of a beat is at bits `[8k+7:8k]`.
- `tx_axis_tkeep_o` out 8: byte enables.
- `tx_axis_tvalid_o` out 1: stream valid.
- `tx_axis_tready_i` in 1: stream ready.
- `tx_axis_tlast_o` out 1: last beat of the frame.
- `tx_axis_tuser_o` out 1: frame error flag; constant 0.

## Operation
- Buffer: register array of `max_frame_bytes_p/8` words, with write pointer `wr_ptr`, read pointer `rd_ptr`, word count `n_words = ceil(len/8)`, and stored length `len_r`.
- IDLE:
  - `frame_data_yumi_o = frame_data_v_i`.
  - The accepted word is a descriptor. `len = frame_data_i[len_width_p-1:0]`; all other bits are ignored.
  - If `1 <= len <= max_frame_bytes_p`: latch `len_r`, clear `wr_ptr`, go to FILL.
  - Otherwise: set `error_o` and stay in IDLE. The bad descriptor is still consumed.
- FILL:
  - `frame_data_yumi_o = frame_data_v_i`.
  - Each accepted word is written to `buf[wr_ptr]` and `wr_ptr` increments.
  - Accepting word `n_words-1` moves to SEND and clears `rd_ptr`.
- SEND:
  - `frame_data_yumi_o = 0`; MMIO writes stall.
  - Outputs: `tx_axis_tvalid_o = 1`, `tdata = buf[rd_ptr]`, `tlast = (rd_ptr == n_words-1)`.
  - `tkeep = 8'hFF` except on the last beat, where it is `(len_r%8 == 0) ? 8'hFF : (8'h1 << (len_r%8)) - 1`.
  - Each beat with `tvalid & tready` increments `rd_ptr`. The `tlast` handshake returns to IDLE.
- `error_o`:
  - Set by a bad descriptor; cleared by `error_clr_i`.
  - If a set and a clear happen in the same cycle, set wins.
  - `error_o` is independent of the state machine.
- Bytes beyond `len_r` in the final payload word are written to the buffer but masked by `tkeep`; their data content is don't-care.

## Timing
- Reset (async assert, sync deassert from the system) forces:
  - state IDLE, all pointers 0, `error_o = 0`;
  - `tvalid_o = 0`, `tlast_o = 0`, `tkeep_o = 0`, `tdata_o = 0`, `tuser_o = 0`, `tx_ext_state_o = 0`, `frame_data_yumi_o = 0`.
  - Buffer contents need no reset.
- `frame_data_yumi_o` is combinational from `frame_data_v_i` and state; there is no registered ready.
- Latency:
  - Descriptor accepted at cycle 0; payload word i accepted no earlier than cycle i+1.
  - `tvalid` rises on the cycle after the last payload word is accepted.
  - With `tready` held high, an N-word frame occupies N cycles in SEND.
- AXIS rules:
  - While `tvalid & !tready`, `tdata`/`tkeep`/`tlast` are held stable.
  - `tvalid` never drops before the `tlast` handshake (except on reset).
- After the `tlast` handshake, IDLE is entered the next cycle. A descriptor may be consumed in that cycle, so the minimum frame-to-frame gap is 1 cycle.
- `tx_ext_state_o` reflects the registered state: it changes the cycle after the triggering handshake.
- Reset asserted mid-FILL or mid-SEND: the frame is discarded, `tvalid` drops asynchronously, and no partial frame is resumed.

## Test plan
- Descriptor `len = 8`, then `64'h8877665544332211` -> one beat: `tdata = 64'h8877665544332211`, `tkeep = 8'hFF`, `tlast = 1`; `tvalid` rises 1 cycle after the payload word; state sequence 0→1→2→0.
- `len = 13` with two words -> beat 0 `tkeep = FF`, `tlast = 0`; beat 1 `tkeep = 8'h1F`, `tlast = 1`.
- `len = 16`, `tready` low for 5 cycles at beat 0 -> beat 0 held stable for 5 cycles; `frame_data_yumi_o = 0` during SEND even with `v = 1`; 2 beats total.
- Descriptors `len = 0` and `len = 1537` -> each consumed, `error_o = 1`, state stays 0, no `tvalid`; `error_clr_i` pulse -> `error_o = 0`; a simultaneous bad descriptor and clear leaves `error_o = 1`.
- `reset_n_i` low for 1 cycle during SEND of a 4-word frame at beat 2 -> `tvalid = 0` immediately, state 0; the following `len = 8` frame transmits correctly.
- `len = 1536`, 192 words, random `tready` -> 192 beats in order, last `tkeep = FF`, `tlast` only on beat 191; a descriptor presented in the cycle after `tlast` is consumed.
